// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the signed-overflow rule used when the result is committed.
package serial_sub_pkg;

  localparam int SUB_DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Subtraction overflows only when the operand signs differ and the result
  // sign departs from the minuend sign.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// Single-bit full subtractor: difference, borrow-out, borrow generate/propagate.
// Purely combinational, no state, no backpressure.
module sub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o,
  output logic g_o,
  output logic p_o
);

  assign g_o    = ~a_i & b_i;
  assign p_o    = ~a_i | b_i;
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = g_o | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor a - b - bin, LSB first, one bit per cycle.
// done pulses WIDTH+1 cycles after an accepted start; start is ignored while busy.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             br_q, br_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             cell_d, cell_bout, cell_g, cell_p;
  logic [WIDTH-1:0] sh_next;

  sub_cell u_cell (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (br_q),
    .d_o    (cell_d),
    .bout_o (cell_bout),
    .g_o    (cell_g),
    .p_o    (cell_p)
  );

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 lands at bit 0.
  assign sh_next = {cell_d, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    br_d    = br_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = cell_bout;
        sh_d  = sh_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          diff_d  = sh_next;
          bout_d  = cell_bout;
          zero_d  = (sh_next == '0);
          ovf_d   = sub_ovf(amsb_q, bmsb_q, sh_next[WIDTH-1]);
        end
      end
      default: begin
        // IDLE and DONE both accept; an illegal encoding falls back to IDLE.
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          sh_d    = '0;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      br_q    <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      br_q    <= br_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  // The cell's direct borrow form must agree with the generate/propagate form.
  borrow_gp_consistent: assert property (@(posedge clk) disable iff (rst)
    cell_bout == (cell_g | (cell_p & br_q)));

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed-vector bench for serial_sub (WIDTH=8): latency, results, hold,
// back-to-back starts, mid-run reset and a reference-model random sweep.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic       busy, done;
  logic [7:0] diff;
  logic       bout, zero, ovf;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       zero;
    logic       ovf;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] last_diff = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One isolated operation: operands scrambled after acceptance, result held
  // during RUN, done exactly 9 edges after the start cycle and one cycle wide.
  task automatic run_op(input vec_t v);
    int   lat;
    logic hold_bad;
    @(negedge clk);
    a = v.a; b = v.b; bin = v.bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    hold_bad = 1'b0;
    for (int c = 2; c <= 20 && lat == 0; c++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      @(posedge clk); #1;
      if (done) lat = c;
      else if (diff !== last_diff) hold_bad = 1'b1;
    end
    check("latency", 32'(lat), 32'd9);
    check("hold_during_run", 32'(hold_bad), 32'd0);
    check("diff", 32'(diff), 32'(v.diff));
    check("bout", 32'(bout), 32'(v.bout));
    check("zero", 32'(zero), 32'(v.zero));
    check("ovf",  32'(ovf),  32'(v.ovf));
    last_diff = v.diff;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  function automatic vec_t model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
    vec_t       v;
    logic [8:0] r;
    r      = {1'b0, ma} - {1'b0, mb} - {8'h00, mbin};
    v.a    = ma;
    v.b    = mb;
    v.bin  = mbin;
    v.diff = r[7:0];
    v.bout = r[8];
    v.zero = (r[7:0] == 8'h00);
    v.ovf  = (ma[7] != mb[7]) && (r[7] != ma[7]);
    return v;
  endfunction

  vec_t vecs[10];
  vec_t bb[3];

  initial begin
    //          a      b      bin   diff   bout  zero  ovf
    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h5A, 8'h59, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0, 1'b0, 1'b0};

    bb[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
    bb[1] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    bb[2] = '{8'h5A, 8'h59, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_flags", 32'({bout, zero, ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Back-to-back: start held high, new operands offered only in DONE cycles.
    begin
      int k;
      int edges;
      @(negedge clk);
      a = bb[0].a; b = bb[0].b; bin = bb[0].bin; start = 1'b1;
      k = 0;
      edges = 0;
      for (int n = 0; n < 60 && k < 3; n++) begin
        @(posedge clk); #1;
        edges++;
        if (done) begin
          check("b2b_interval", 32'(edges), 32'd9);
          check("b2b_diff", 32'(diff), 32'(bb[k].diff));
          check("b2b_flags", 32'({bout, zero, ovf}), 32'({bb[k].bout, bb[k].zero, bb[k].ovf}));
          edges = 0;
          k++;
          if (k < 3) begin
            a = bb[k].a; b = bb[k].b; bin = bb[k].bin;
          end
        end else begin
          a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        end
      end
      check("b2b_count", 32'(k), 32'd3);
      start = 1'b0;
      last_diff = bb[2].diff;
      @(posedge clk); #1;
    end

    // Reset in the 4th RUN cycle abandons the operation.
    begin
      logic seen;
      @(negedge clk);
      a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_diff", 32'(diff), 32'd0);
      check("midrst_flags", 32'({bout, zero, ovf}), 32'd0);
      last_diff = 8'h00;
      seen = 1'b0;
      repeat (12) begin
        @(posedge clk); #1;
        if (done) seen = 1'b1;
      end
      check("midrst_no_done", 32'(seen), 32'd0);
      run_op(model(8'h10, 8'h01, 1'b0));
    end

    for (int i = 0; i < 200; i++)
      run_op(model(8'($urandom), 8'($urandom), 1'($urandom)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
